// File: rtl/sfx_arbiter.sv
// Fixed-priority arbiter sharing the audio DAC path between tone requesters.
// The granted requester plays a square wave for a latched number of beats.
module sfx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter logic [31:0] AMPLITUDE   = 32'd100000000,
  parameter int unsigned BEAT_CYCLES = 2500000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [19*NUM_REQ-1:0]  req_period,
  input  logic [8*NUM_REQ-1:0]   req_beats,
  input  logic                   audio_out_allowed,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [NUM_REQ-1:0]     done,
  output logic                   write_audio_out,
  output logic [31:0]            left_channel_audio_out,
  output logic [31:0]            right_channel_audio_out
);

  localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BTW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BTW-1:0] BT_LAST = BTW'(BEAT_CYCLES - 1);
  localparam logic [31:0]    NEG_AMP = ~AMPLITUDE + 32'd1;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      g_q, g_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [18:0]        per_q, per_d;
  logic [18:0]        hp_cnt_q, hp_cnt_d;
  logic [7:0]         beats_q, beats_d;
  logic [7:0]         bc_q, bc_d;
  logic [BTW-1:0]     bt_cnt_q, bt_cnt_d;
  logic               snd_q, snd_d;
  logic [31:0]        sample_q, sample_d;

  logic          any_req, cur_req, higher;
  logic [IW-1:0] win_idx;
  logic [18:0]   sel_per;
  logic [7:0]    sel_beats;
  logic          playing, preempt, abort, complete, load, stop;
  logic          bt_wrap, hp_wrap;

  // Winner lookup, granted-requester level and higher-priority detection.
  always_comb begin
    any_req   = |req;
    win_idx   = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req[i-1]) win_idx = IW'(i - 1);
    end
    sel_per   = '0;
    sel_beats = '0;
    cur_req   = 1'b0;
    higher    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win_idx) begin
        sel_per   = req_period[19*i +: 19];
        sel_beats = req_beats[8*i +: 8];
      end
      if (IW'(i) == g_q) cur_req = req[i];
      if (req[i] && (IW'(i) < g_q)) higher = 1'b1;
    end
    if (sel_beats == '0) sel_beats = 8'd1;
  end

  always_comb begin
    playing  = (state_q == S_PLAY);
    preempt  = playing && higher;
    abort    = playing && !cur_req;
    bt_wrap  = (bt_cnt_q == BT_LAST);
    hp_wrap  = (per_q != '0) && (hp_cnt_q == per_q);
    complete = playing && bt_wrap && (bc_q == beats_q - 8'd1);
    // Preemption outranks abort and completion; abort outranks completion.
    load     = (!playing && any_req) || preempt;
    stop     = playing && !preempt && (abort || complete);

    state_d  = state_q;
    g_d      = g_q;
    grant_d  = grant_q;
    per_d    = per_q;
    beats_d  = beats_q;
    hp_cnt_d = hp_cnt_q;
    bt_cnt_d = bt_cnt_q;
    bc_d     = bc_q;
    snd_d    = snd_q;
    sample_d = '0;

    if (load) begin
      state_d  = S_PLAY;
      g_d      = win_idx;
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_d[i] = (IW'(i) == win_idx);
      per_d    = sel_per;
      beats_d  = sel_beats;
      hp_cnt_d = '0;
      bt_cnt_d = '0;
      bc_d     = '0;
      snd_d    = 1'b1;
      sample_d = (sel_per != '0) ? AMPLITUDE : '0;
    end else if (stop) begin
      state_d  = S_IDLE;
      grant_d  = '0;
      hp_cnt_d = '0;
      bt_cnt_d = '0;
      bc_d     = '0;
      snd_d    = 1'b1;
    end else if (playing) begin
      hp_cnt_d = hp_wrap ? '0 : hp_cnt_q + 1'b1;
      snd_d    = hp_wrap ? ~snd_q : snd_q;
      bt_cnt_d = bt_wrap ? '0 : bt_cnt_q + 1'b1;
      bc_d     = bt_wrap ? bc_q + 8'd1 : bc_q;
      // Sample is registered from the next phase so it lines up with snd.
      sample_d = (per_q != '0) ? (snd_d ? AMPLITUDE : NEG_AMP) : '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      grant_q  <= '0;
      per_q    <= '0;
      beats_q  <= '0;
      hp_cnt_q <= '0;
      bt_cnt_q <= '0;
      bc_q     <= '0;
      snd_q    <= 1'b1;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      grant_q  <= grant_d;
      per_q    <= per_d;
      beats_q  <= beats_d;
      hp_cnt_q <= hp_cnt_d;
      bt_cnt_q <= bt_cnt_d;
      bc_q     <= bc_d;
      snd_q    <= snd_d;
      sample_q <= sample_d;
    end
  end

  // Done marks the final cycle of a tone, so it is qualified by the live inputs.
  assign done = (complete && !abort && !preempt && !reset) ? grant_q : '0;
  assign grant                   = grant_q;
  assign busy                    = (state_q == S_PLAY);
  assign write_audio_out         = audio_out_allowed;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed and randomized bench for sfx_arbiter against a tone-index model.
module tb_sfx_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned BC  = 10;
  localparam logic [31:0] AMP = 32'd100000000;
  localparam logic [31:0] NEG = 32'd0 - AMP;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [19*NR-1:0] req_period;
  logic [8*NR-1:0]  req_beats;
  logic          allowed;
  logic [NR-1:0] grant, done;
  logic          busy, wr;
  logic [31:0]   left, right;

  sfx_arbiter #(.NUM_REQ(NR), .AMPLITUDE(AMP), .BEAT_CYCLES(BC)) dut (
    .CLOCK_50(clk), .reset(reset), .req(req), .req_period(req_period),
    .req_beats(req_beats), .audio_out_allowed(allowed), .grant(grant),
    .busy(busy), .done(done), .write_audio_out(wr),
    .left_channel_audio_out(left), .right_channel_audio_out(right)
  );

  always #5 clk = ~clk;

  // Model: owner index, 1-based cycle number within the current tone.
  bit m_busy;
  int m_g, m_n, m_per, m_beats;
  int checks, passed, fails;
  logic [NR-1:0] drop_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] exp_grant();
    return m_busy ? NR'(1 << m_g) : '0;
  endfunction

  function automatic logic [NR-1:0] exp_done();
    bit hi;
    hi = 0;
    for (int j = 0; j < m_g; j++) if (req[j]) hi = 1;
    if (m_busy && !reset && req[m_g] && !hi && (m_n == m_beats * int'(BC)))
      return NR'(1 << m_g);
    return '0;
  endfunction

  function automatic logic [31:0] exp_sample();
    if (!m_busy || m_per == 0) return '0;
    return (((m_n - 1) / (m_per + 1)) % 2 == 0) ? AMP : NEG;
  endfunction

  task automatic start_tone();
    int w, b;
    w = 0;
    for (int i = NR - 1; i >= 0; i--) if (req[i]) w = i;
    m_g     = w;
    m_per   = int'(req_period[19*w +: 19]);
    b       = int'(req_beats[8*w +: 8]);
    m_beats = (b == 0) ? 1 : b;
    m_n     = 1;
    m_busy  = 1;
  endtask

  task automatic model_update();
    bit hi;
    hi = 0;
    if (m_busy) for (int j = 0; j < m_g; j++) if (req[j]) hi = 1;
    if (reset) m_busy = 0;
    else if (!m_busy) begin
      if (|req) start_tone();
    end else if (hi) start_tone();
    else if (!req[m_g]) m_busy = 0;
    else if (m_n == m_beats * int'(BC)) m_busy = 0;
    else m_n++;
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge,
  // then release any requester whose tone just completed.
  task automatic tick();
    logic [NR-1:0] ed;
    @(negedge clk);
    #1;
    ed = exp_done();
    chk("grant", 32'(grant), 32'(exp_grant()));
    chk("busy",  32'(busy),  32'(m_busy));
    chk("done",  32'(done),  32'(ed));
    chk("left",  left,  exp_sample());
    chk("right", right, exp_sample());
    chk("write", 32'(wr), 32'(allowed));
    drop_mask = ed;
    @(posedge clk);
    model_update();
    #1;
    req = req & ~drop_mask;
  endtask

  task automatic run(input int n, input bit toggle);
    for (int k = 0; k < n; k++) begin
      if (toggle) allowed = ~allowed;
      tick();
    end
  endtask

  task automatic set_tone(input int idx, input int per, input int beats);
    req_period[19*idx +: 19] = 19'(per);
    req_beats[8*idx +: 8]    = 8'(beats);
  endtask

  initial begin
    checks = 0; passed = 0; fails = 0; m_busy = 0;
    m_g = 0; m_n = 0; m_per = 0; m_beats = 1;
    reset = 1'b1; req = '0; req_period = '0; req_beats = '0; allowed = 1'b1;
    run(2, 0);
    reset = 1'b0;
    run(2, 0);

    // Single tone, period 3, two beats.
    set_tone(2, 3, 2); req = 4'b0100;
    tick();
    chk("s1_grant", 32'(grant), 32'(4'b0100));
    run(24, 0);

    // Simultaneous requests; lower index wins, other follows after IDLE gap.
    set_tone(1, 1, 1); set_tone(3, 2, 1); req = 4'b1010;
    run(26, 0);

    // Preemption of requester 3 by requester 0 at cycle 7.
    set_tone(3, 4, 2); set_tone(0, 2, 1); req = 4'b1000;
    run(7, 0);
    req[0] = 1'b1;
    run(40, 0);

    // Rest tone with toggling write permission.
    set_tone(2, 0, 1); req = 4'b0100;
    run(14, 1);

    // Abort mid-play.
    set_tone(1, 2, 3); req = 4'b0010;
    run(6, 0);
    req[1] = 1'b0;
    run(3, 0);

    // Reset at cycle 5 of play.
    set_tone(0, 1, 2); req = 4'b0001;
    run(5, 0);
    reset = 1'b1; req = '0;
    run(1, 0);
    reset = 1'b0;
    run(2, 0);

    // Beats of zero plays as one beat; mid-play input changes ignored.
    set_tone(3, 1, 0); req = 4'b1000;
    run(3, 0);
    set_tone(3, 7, 5);
    run(10, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      allowed = 1'($urandom_range(0, 1));
      reset   = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NR; i++) begin
        set_tone(i, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        if (!req[i] && $urandom_range(0, 24) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 149) == 0) req[i] = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sfx_arbiter.md
# sfx_arbiter

Shares the single audio DAC path between up to four sound-effect requesters, such as game events and the background tune. It grants one requester at a time by fixed priority, with preemption by higher priority. For the granted requester it generates a square-wave tone with a latched half-period and beat count. It drives the Audio_Controller output handshake with one sample per `audio_out_allowed` cycle.

## Interface
- `NUM_REQ`, 4: number of requesters (2..4); index 0 has the highest priority.
- `AMPLITUDE`, 32'd100000000: square-wave peak; samples are +AMPLITUDE or -AMPLITUDE.
- `BEAT_CYCLES`, 2500000: CLOCK_50 cycles per beat (≥2).

- `CLOCK_50`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  level request per requester; held until `done[i]`.
- `req_period`  in  19*NUM_REQ  half-period per requester, slice i = [19i+18:19i]; 0 means rest (silence).
- `req_beats`  in  8*NUM_REQ  duration in beats per requester, slice i = [8i+7:8i]; 0 is treated as 1.
- `audio_out_allowed`  in  1  Audio_Controller output FIFO has space.
- `grant`  out  NUM_REQ  one-hot grant, or all-zero.
- `busy`  out  1  high in PLAY.
- `done`  out  NUM_REQ  one-cycle pulse on normal completion.
- `write_audio_out`  out  1  sample write strobe.
- `left_channel_audio_out`, `right_channel_audio_out`  out  32 each  current sample; both channels are identical.

## Operation
- Two-state FSM: IDLE and PLAY.
- IDLE → PLAY when any `req` is high.
  - Winner is the lowest asserted index.
  - Latch its period into `per_q` and its beats into `beats_q`; a beats value of 0 is latched as 1.
  - Clear the half-period counter `hp_cnt`, the beat timer `bt_cnt` and the beat count `bc`. Set the phase `snd` to 1.
- In PLAY, each cycle:
  - `hp_cnt` advances.
  - When `hp_cnt == per_q` and `per_q != 0`: `hp_cnt` returns to 0 and `snd` toggles. The half-period is therefore `per_q+1` cycles.
  - `bt_cnt` counts 0..BEAT_CYCLES-1. On wrap, `bc` increments.
- Completion: `bt_cnt` wraps and `bc == beats_q-1`. Then pulse `done[g]`, clear `grant`, and go to IDLE.
- Abort (granted `req[g]` deasserts): go to IDLE next cycle with no `done` pulse.
- Preemption (a `req[j]` with `j < g` asserts): in the same transition, reload the latches for j, clear the counters, set `snd=1`, and grant j. There is no `done` for g; g restarts from the beginning when re-granted.
- Priority of simultaneous events:
  - Abort beats completion.
  - Preemption beats both: neither `done[g]` nor any abort effect occurs.
- Sample value:
  - PLAY with `per_q != 0`: `snd ? AMPLITUDE : -AMPLITUDE` (two's complement).
  - Otherwise 0.
- `write_audio_out = audio_out_allowed` in every state, so the DAC FIFO is always fed; IDLE feeds zeros.
- Sample values are registered. The write strobe is combinational from `audio_out_allowed`.

## Timing
- Reset values:
  - FSM = IDLE.
  - `grant`, `done` and `busy` = 0.
  - Counters = 0; `snd` = 1.
  - Samples = 0.
  - `write_audio_out` follows `audio_out_allowed`.
- Grant latency: `req` high at edge k → `grant` and `busy` high after edge k+1. The first nonzero sample is visible the same cycle as `grant`.
- Tone duration: exactly `beats_q*BEAT_CYCLES` cycles from the first `grant` cycle to the cycle carrying the `done` pulse, inclusive of the done cycle. `grant` is low in the cycle after `done`.
- Back-to-back: after `done` there is at least one IDLE cycle before the next `grant`. A still-asserted `req` is re-granted at edge+1 of that IDLE cycle.
- Inputs are sampled only at grant, so changing `req_period` or `req_beats` mid-play has no effect.
- Reset mid-PLAY: outputs return to reset values at the next edge, with no `done` pulse.

## Test plan
- BEAT_CYCLES=10; `req[2]` with period=3, beats=2 → `grant`=4'b0100 after 1 cycle. Sample is +A for 4 cycles, then -A for 4 cycles, alternating. `done[2]` pulses on cycle 20 of `grant`, then `grant`=0.
- `req[1]` and `req[3]` asserted together → `grant[1]` only. `req[3]` is granted after `done[1]` plus 1 IDLE cycle.
- `req[3]` playing; at cycle 7 `req[0]` asserts → `grant` switches to 4'b0001 next edge, with no `done[3]`. `req[3]` is re-granted after `done[0]` and plays its full duration.
- period=0, beats=1 → samples stay 0 for 10 cycles, then `done` pulses. `write_audio_out` tracks a toggling `audio_out_allowed` throughout.
- Deassert the granted `req` mid-play → IDLE and samples 0 next cycle, no `done`.
- `reset` at cycle 5 of PLAY → `grant`, `busy` and samples all 0 next cycle, no `done`.
- beats=0 → behaves as beats=1, with `done` at cycle 10.
